iopage_reg_bank: RTL and testbench
==================================

# iopage_reg_bank

Parametrised bank of NUM_REGS 16-bit I/O-page registers, each with its own storage, for PSW-style and small device control registers. Decodes a contiguous, word-aligned window of the 13-bit I/O page and supports word and byte writes. Access completes after a programmable number of wait states, with an `ack` held until the master drops its request. The CPU core can load any register directly through a hardware write port, and that port takes priority over bus writes.

## Interface
- BASE_ADDR, 13'o17770, byte address of register 0; must be even; register i sits at BASE_ADDR + 2*i
- NUM_REGS, 4, number of registers (1..16)
- WAIT_STATES, 1, cycles between request capture and commit (0..15)
- RST_VAL, {NUM_REGS{16'h0000}}, packed per-register reset values, register i at [16*i+15:16*i]
- WR_MASK, {NUM_REGS{16'hFFFF}}, packed per-bit bus-writable mask; masked bits ignore bus writes but accept `hw_wr`

- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low; one clock; sampled on rising edge of `clk`
- iopage_addr  in  13  byte address within I/O page
- data_in  in  16  bus write data
- iopage_rd  in  1  read request, level, held until `ack`
- iopage_wr  in  1  write request, level, held until `ack`
- iopage_byte_op  in  1  byte access; `iopage_addr[0]` selects the byte
- data_out  out  16  registered read data
- decode  out  1  combinational: `iopage_addr[12:1]` is inside the window
- ack  out  1  access complete; held until `iopage_rd` and `iopage_wr` are both low
- reg_out  out  16*NUM_REGS  current contents of all registers
- hw_wr  in  NUM_REGS  per-register core load strobe
- hw_data  in  16*NUM_REGS  core load data
- io_wr  out  NUM_REGS  one-cycle pulse on the cycle a bus write commits to register i

## Operation
- Index: idx = (iopage_addr - BASE_ADDR) >> 1. `decode` = (iopage_addr[12:1] >= BASE_ADDR[12:1]) && (idx < NUM_REGS).
- FSM states:
  - IDLE to WAIT when (rd|wr) && decode. On that edge, capture idx, op, byte flag, addr[0] and data_in. Counter loads WAIT_STATES-1.
  - IDLE to ACK directly when WAIT_STATES = 0. The commit happens on the same edge.
  - WAIT decrements the counter each cycle. At 0 it commits and moves to ACK.
  - ACK holds `ack`=1 and moves to IDLE on the first edge with rd=0 and wr=0.
- Commit, write:
  - Word: reg = (reg & ~WR_MASK) | (data & WR_MASK).
  - Byte, even address: low byte only, using data[7:0].
  - Byte, odd address: high byte only, using data[15:8].
  - `io_wr[idx]` pulses for the commit cycle.
- Commit, read: data_out <= reg[idx]. Byte reads return the full word.
- rd and wr both high: treated as a write.
- Requests outside the window: ignored. FSM stays IDLE, `ack` stays 0.
- Request dropped in WAIT: abort. Return to IDLE, no commit, no `ack`, no `io_wr`.
- `hw_wr[i]` loads all 16 bits of hw_data, ignoring WR_MASK. It is honoured in any state.
- Same register, same edge as a bus write commit: hw_wr wins entirely. `io_wr` still pulses and `ack` still completes.
- A read committing on the same edge as hw_wr to that register returns the pre-load value.

## Timing
- Reset state: all regs = RST_VAL, data_out = 0, ack = 0, io_wr = 0, FSM = IDLE, counter = 0. Reset mid-access aborts with no commit.
- `decode` is combinational from `iopage_addr`.
- Latency, request seen to `ack` high: WAIT_STATES+1 edges. `data_out` is valid on the same edge as `ack`.
- reg_out reflects a commit or hw_wr the cycle after the edge.
- Back-to-back accesses: at least one IDLE cycle between them, because the request must drop first.

## Structure
- Shared package `iopage_pkg`:
  - IOPAGE_AW = 13 and WORD_W = 16.
  - The FSM state enum (IDLE, WAIT, ACK).
  - An index-from-address helper function.
- Sub-module `iopage_reg_slice`: one register with byte-lane write, WR_MASK and hw_wr priority. Instantiated NUM_REGS times with a generate loop.
- The FSM, counter and read mux live in the top level.

## Test plan
- Reset, then read 13'o17776 with defaults → `ack` after 2 edges, data_out = 16'h0000, `io_wr` = 0.
- Word write 16'hA5F0 to 13'o17772 → reg_out[31:16] = 16'hA5F0, `io_wr` = 4'b0010 for one cycle, `ack` held until wr drops.
- Byte write to 13'o17775 with data_in = 16'h3C00, register 2 previously 16'h1234 → register 2 = 16'h3C34.
- WR_MASK[63:48] = 16'h00FF, word write 16'hFFFF to 13'o17776 from 0 → register 3 = 16'h00FF. hw_wr[3] with 16'hE000 then gives 16'hE000.
- hw_wr[1] = 16'h0007 on the commit edge of a bus write of 16'h1111 to 13'o17772 → register 1 = 16'h0007.
- Two cases:
  - Address 13'o17766 → decode = 0 and no ack.
  - WAIT_STATES = 3 with wr dropped after 1 cycle → no commit and no ack. Reset asserted in WAIT → all outputs return to reset values.

Source files
------------

// File: rtl/iopage_pkg.sv
// Shared widths, FSM state type and address-to-index helper for the I/O-page
// register bank.
package iopage_pkg;

   localparam int IOPAGE_AW = 13;
   localparam int WORD_W    = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } iopage_state_t;

   // Word index of a byte address relative to an even window base.
   function automatic logic [IOPAGE_AW-2:0] addr_to_idx(
      input logic [IOPAGE_AW-1:0] addr,
      input logic [IOPAGE_AW-1:0] base
   );
      return (IOPAGE_AW-1)'((addr - base) >> 1);
   endfunction

endpackage

// File: rtl/iopage_reg_slice.sv
// One 16-bit I/O-page register: byte-lane bus write limited by WR_MASK, with the
// core hardware load taking priority over any bus write on the same edge.
module iopage_reg_slice
   import iopage_pkg::*;
#(
   parameter logic [WORD_W-1:0] RST_VAL = '0,
   parameter logic [WORD_W-1:0] WR_MASK = '1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              bus_we_i,
   input  logic              byte_op_i,
   input  logic              byte_hi_i,
   input  logic [WORD_W-1:0] wdata_i,
   input  logic              hw_we_i,
   input  logic [WORD_W-1:0] hw_data_i,
   output logic [WORD_W-1:0] q_o
);

   logic [WORD_W-1:0] q_q;
   logic [WORD_W-1:0] q_d;
   logic [WORD_W-1:0] lane;
   logic [WORD_W-1:0] bus_val;

   always_comb begin
      lane = '1;
      if (byte_op_i) begin
         lane = byte_hi_i ? 16'hFF00 : 16'h00FF;
      end
      // Byte writes take the byte matching the lane, so replicate it into both halves.
      bus_val = byte_op_i ? {2{byte_hi_i ? wdata_i[15:8] : wdata_i[7:0]}} : wdata_i;
      q_d = q_q;
      if (hw_we_i) begin
         q_d = hw_data_i;
      end else if (bus_we_i) begin
         q_d = (q_q & ~(lane & WR_MASK)) | (bus_val & lane & WR_MASK);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         q_q <= RST_VAL;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/iopage_reg_bank.sv
// Bank of NUM_REGS I/O-page registers: window decode, wait-state access FSM,
// registered read mux and per-register write strobes.
module iopage_reg_bank
   import iopage_pkg::*;
#(
   parameter logic [IOPAGE_AW-1:0]       BASE_ADDR   = 13'o17770,
   parameter int                         NUM_REGS    = 4,
   parameter int                         WAIT_STATES = 1,
   parameter logic [WORD_W*NUM_REGS-1:0] RST_VAL     = {NUM_REGS{16'h0000}},
   parameter logic [WORD_W*NUM_REGS-1:0] WR_MASK     = {NUM_REGS{16'hFFFF}}
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [IOPAGE_AW-1:0]         iopage_addr,
   input  logic [WORD_W-1:0]            data_in,
   input  logic                         iopage_rd,
   input  logic                         iopage_wr,
   input  logic                         iopage_byte_op,
   output logic [WORD_W-1:0]            data_out,
   output logic                         decode,
   output logic                         ack,
   output logic [WORD_W*NUM_REGS-1:0]   reg_out,
   input  logic [NUM_REGS-1:0]          hw_wr,
   input  logic [WORD_W*NUM_REGS-1:0]   hw_data,
   output logic [NUM_REGS-1:0]          io_wr
);

   localparam bit       NO_WAIT  = (WAIT_STATES == 0);
   localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   iopage_state_t     state_q;
   logic [3:0]        cnt_q;
   logic [3:0]        idx_q;
   logic              wr_q;
   logic              byte_q;
   logic              hi_q;
   logic [WORD_W-1:0] data_q;
   logic [WORD_W-1:0] data_out_q;
   logic              ack_q;
   logic [NUM_REGS-1:0] io_wr_q;

   logic                 req;
   logic [IOPAGE_AW-2:0] idx_full;
   logic                 commit;
   logic                 cm_wr;
   logic                 cm_byte;
   logic                 cm_hi;
   logic [3:0]           cm_idx;
   logic [WORD_W-1:0]    cm_data;
   logic [WORD_W-1:0]    rd_word;
   logic [NUM_REGS-1:0]  bus_we;
   logic [WORD_W-1:0]    regs [NUM_REGS];

   assign req      = iopage_rd | iopage_wr;
   assign idx_full = addr_to_idx(iopage_addr, BASE_ADDR);
   assign decode   = (iopage_addr[IOPAGE_AW-1:1] >= BASE_ADDR[IOPAGE_AW-1:1])
                     && (idx_full < (IOPAGE_AW-1)'(NUM_REGS));

   // With no wait states the live bus fields commit on the capture edge itself.
   always_comb begin
      commit  = 1'b0;
      cm_wr   = wr_q;
      cm_byte = byte_q;
      cm_hi   = hi_q;
      cm_idx  = idx_q;
      cm_data = data_q;
      if (state_q == IDLE) begin
         cm_wr   = iopage_wr;
         cm_byte = iopage_byte_op;
         cm_hi   = iopage_addr[0];
         cm_idx  = idx_full[3:0];
         cm_data = data_in;
         commit  = NO_WAIT && req && decode;
      end else if (state_q == WAIT) begin
         commit = req && (cnt_q == 4'd0);
      end
   end

   always_comb begin
      rd_word = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (cm_idx == 4'(i)) begin
            rd_word = regs[i];
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         assign bus_we[gi] = commit && cm_wr && (cm_idx == 4'(gi));

         iopage_reg_slice #(
            .RST_VAL (RST_VAL[WORD_W*gi +: WORD_W]),
            .WR_MASK (WR_MASK[WORD_W*gi +: WORD_W])
         ) u_slice (
            .clk       (clk),
            .reset     (reset),
            .bus_we_i  (bus_we[gi]),
            .byte_op_i (cm_byte),
            .byte_hi_i (cm_hi),
            .wdata_i   (cm_data),
            .hw_we_i   (hw_wr[gi]),
            .hw_data_i (hw_data[WORD_W*gi +: WORD_W]),
            .q_o       (regs[gi])
         );

         assign reg_out[WORD_W*gi +: WORD_W] = regs[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         idx_q      <= 4'd0;
         wr_q       <= 1'b0;
         byte_q     <= 1'b0;
         hi_q       <= 1'b0;
         data_q     <= '0;
         data_out_q <= '0;
         ack_q      <= 1'b0;
         io_wr_q    <= '0;
      end else begin
         io_wr_q <= bus_we;
         if (commit && !cm_wr) begin
            data_out_q <= rd_word;
         end
         case (state_q)
            IDLE: begin
               if (req && decode) begin
                  idx_q  <= idx_full[3:0];
                  wr_q   <= iopage_wr;
                  byte_q <= iopage_byte_op;
                  hi_q   <= iopage_addr[0];
                  data_q <= data_in;
                  if (NO_WAIT) begin
                     state_q <= ACK;
                     ack_q   <= 1'b1;
                  end else begin
                     state_q <= WAIT;
                     cnt_q   <= CNT_INIT;
                  end
               end
            end
            WAIT: begin
               if (!req) begin
                  state_q <= IDLE;
                  cnt_q   <= 4'd0;
               end else if (cnt_q == 4'd0) begin
                  state_q <= ACK;
                  ack_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ACK: begin
               if (!req) begin
                  state_q <= IDLE;
                  ack_q   <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               ack_q   <= 1'b0;
            end
         endcase
      end
   end

   assign data_out = data_out_q;
   assign ack      = ack_q;
   assign io_wr    = io_wr_q;

endmodule

// File: tb/tb_iopage_reg_bank.sv
// Directed plus randomized checks of iopage_reg_bank against a word-level
// register model; a second instance with three wait states covers aborts.
module tb_iopage_reg_bank;

   localparam logic [12:0] BASE = 13'o17770;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [12:0] iopage_addr = '0;
   logic [15:0] data_in = '0;
   logic        iopage_rd = 1'b0, iopage_wr = 1'b0, iopage_byte_op = 1'b0;
   logic [15:0] data_out;
   logic        decode, ack;
   logic [63:0] reg_out;
   logic [3:0]  hw_wr = '0;
   logic [63:0] hw_data = '0;
   logic [3:0]  io_wr;

   logic        rd3 = 1'b0, wr3 = 1'b0;
   logic [15:0] data_out3;
   logic        decode3, ack3;
   logic [63:0] reg_out3;
   logic [3:0]  hw_wr3 = '0;
   logic [63:0] hw_data3 = '0;
   logic [3:0]  io_wr3;

   int vectors = 0;
   int miscompares = 0;

   logic [15:0] model [4];
   logic [15:0] mask  [4];

   always #5 clk = ~clk;

   iopage_reg_bank #(
      .BASE_ADDR(BASE), .NUM_REGS(4), .WAIT_STATES(1),
      .RST_VAL({4{16'h0000}}), .WR_MASK({16'h00FF, {3{16'hFFFF}}})
   ) dut (
      .clk(clk), .reset(reset), .iopage_addr(iopage_addr), .data_in(data_in),
      .iopage_rd(iopage_rd), .iopage_wr(iopage_wr), .iopage_byte_op(iopage_byte_op),
      .data_out(data_out), .decode(decode), .ack(ack), .reg_out(reg_out),
      .hw_wr(hw_wr), .hw_data(hw_data), .io_wr(io_wr)
   );

   iopage_reg_bank #(
      .BASE_ADDR(BASE), .NUM_REGS(4), .WAIT_STATES(3)
   ) dut3 (
      .clk(clk), .reset(reset), .iopage_addr(iopage_addr), .data_in(data_in),
      .iopage_rd(rd3), .iopage_wr(wr3), .iopage_byte_op(iopage_byte_op),
      .data_out(data_out3), .decode(decode3), .ack(ack3), .reg_out(reg_out3),
      .hw_wr(hw_wr3), .hw_data(hw_data3), .io_wr(io_wr3)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] packed_model();
      logic [63:0] p;
      for (int i = 0; i < 4; i++) p[16*i +: 16] = model[i];
      return p;
   endfunction

   // Reference write rule: bytes selected by the access, limited to the writable bits.
   function automatic logic [15:0] apply_write(input logic [15:0] old, input logic [15:0] m,
                                                input logic bop, input logic hi,
                                                input logic [15:0] d);
      logic [15:0] lanes, eff, wd;
      lanes = !bop ? 16'hFFFF : (hi ? 16'hFF00 : 16'h00FF);
      wd    = !bop ? d : (hi ? {d[15:8], 8'h00} : {8'h00, d[7:0]});
      eff   = lanes & m;
      return (old & ~eff) | (wd & eff);
   endfunction

   // Runs one access on the main instance: waits for ack, checks ack holds
   // with io_wr quiet, drops the request and checks ack falls.
   task automatic access(input logic [12:0] a, input bit rd, input bit wr, input bit bop,
                         input logic [15:0] d, output logic [15:0] rdata,
                         output int lat, output logic [3:0] iow_seen);
      iopage_addr = a; data_in = d; iopage_rd = rd; iopage_wr = wr; iopage_byte_op = bop;
      lat = 0; iow_seen = '0;
      while (!ack && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         iow_seen |= io_wr;
      end
      rdata = data_out;
      @(posedge clk); #1;
      chk("ack_hold", {63'b0, ack}, 64'd1);
      chk("io_wr_single_pulse", {60'b0, io_wr}, 64'd0);
      iopage_rd = 1'b0; iopage_wr = 1'b0;
      @(posedge clk); #1;
      chk("ack_release", {63'b0, ack}, 64'd0);
   endtask

   task automatic hw_load(input int i, input logic [15:0] d);
      hw_wr = '0; hw_data = '0;
      hw_wr[i] = 1'b1;
      hw_data[16*i +: 16] = d;
      @(posedge clk); #1;
      hw_wr = '0;
      model[i] = d;
   endtask

   initial begin
      logic [15:0] rdata, d;
      logic [3:0]  iow, iow3;
      logic [12:0] a;
      int lat, idx, kind, any_ack;
      bit bop, hi;

      for (int i = 0; i < 4; i++) begin
         model[i] = 16'h0000;
         mask[i]  = (i == 3) ? 16'h00FF : 16'hFFFF;
      end

      // Reset state
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_reg_out", reg_out, 64'd0);
      chk("reset_data_out", {48'b0, data_out}, 64'd0);
      chk("reset_ack", {63'b0, ack}, 64'd0);
      chk("reset_io_wr", {60'b0, io_wr}, 64'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Read 17776 with defaults
      access(13'o17776, 1, 0, 0, 16'h0, rdata, lat, iow);
      chk("rd_default_lat", 64'(lat), 64'd2);
      chk("rd_default_data", {48'b0, rdata}, 64'd0);
      chk("rd_default_io_wr", {60'b0, iow}, 64'd0);

      // Word write A5F0 to register 1
      access(13'o17772, 0, 1, 0, 16'hA5F0, rdata, lat, iow);
      model[1] = 16'hA5F0;
      chk("wr_word_lat", 64'(lat), 64'd2);
      chk("wr_word_reg1", {48'b0, reg_out[31:16]}, 64'h A5F0);
      chk("wr_word_io_wr", {60'b0, iow}, 64'b0010);

      // Byte write to the odd address of register 2
      access(13'o17774, 0, 1, 0, 16'h1234, rdata, lat, iow);
      access(13'o17775, 0, 1, 1, 16'h3C00, rdata, lat, iow);
      model[2] = 16'h3C34;
      chk("wr_byte_hi_reg2", {48'b0, reg_out[47:32]}, 64'h3C34);

      // Masked register 3, then hardware load ignoring the mask
      access(13'o17776, 0, 1, 0, 16'hFFFF, rdata, lat, iow);
      model[3] = 16'h00FF;
      chk("wr_masked_reg3", {48'b0, reg_out[63:48]}, 64'h00FF);
      hw_load(3, 16'hE000);
      chk("hw_load_reg3", {48'b0, reg_out[63:48]}, 64'hE000);

      // hw_wr on the same edge as a bus write commit
      iopage_addr = 13'o17772; data_in = 16'h1111; iopage_wr = 1'b1; iopage_byte_op = 1'b0;
      @(posedge clk); #1;
      hw_wr = 4'b0010; hw_data = '0; hw_data[31:16] = 16'h0007;
      @(posedge clk); #1;
      hw_wr = '0;
      model[1] = 16'h0007;
      chk("collide_ack", {63'b0, ack}, 64'd1);
      chk("collide_io_wr", {60'b0, io_wr}, 64'b0010);
      chk("collide_reg1", {48'b0, reg_out[31:16]}, 64'h0007);
      iopage_wr = 1'b0;
      @(posedge clk); #1;

      // Out-of-window address
      iopage_addr = 13'o17766; iopage_rd = 1'b1;
      #1;
      chk("oow_decode", {63'b0, decode}, 64'd0);
      any_ack = 0;
      repeat (4) begin @(posedge clk); #1; if (ack) any_ack = 1; end
      chk("oow_no_ack", 64'(any_ack), 64'd0);
      iopage_rd = 1'b0;
      @(posedge clk); #1;

      // Randomized transactions against the model
      for (int n = 0; n < 80; n++) begin
         kind = $urandom_range(0, 9);
         if (kind == 0) begin
            a = 13'($urandom_range(0, 32'(BASE) - 1));
            iopage_addr = a; iopage_rd = 1'b1; iopage_wr = 1'($urandom_range(0, 1));
            data_in = 16'($urandom);
            #1;
            chk("rnd_oow_decode", {63'b0, decode}, 64'd0);
            any_ack = 0;
            repeat (3) begin @(posedge clk); #1; if (ack || io_wr != 0) any_ack = 1; end
            chk("rnd_oow_quiet", 64'(any_ack), 64'd0);
            iopage_rd = 1'b0; iopage_wr = 1'b0;
            @(posedge clk); #1;
         end else if (kind == 1) begin
            hw_load($urandom_range(0, 3), 16'($urandom));
         end else begin
            idx = $urandom_range(0, 3);
            bop = 1'($urandom_range(0, 1));
            hi  = 1'($urandom_range(0, 1));
            d   = 16'($urandom);
            a   = BASE + 13'(2 * idx) + 13'(hi);
            if (kind <= 4) begin
               access(a, 1, 0, bop, d, rdata, lat, iow);
               chk("rnd_rd_data", {48'b0, rdata}, {48'b0, model[idx]});
               chk("rnd_rd_io_wr", {60'b0, iow}, 64'd0);
            end else begin
               access(a, (kind == 9), 1, bop, d, rdata, lat, iow);
               model[idx] = apply_write(model[idx], mask[idx], bop, hi, d);
               chk("rnd_wr_io_wr", {60'b0, iow}, 64'(1 << idx));
            end
            chk("rnd_lat", 64'(lat), 64'd2);
         end
         chk("rnd_reg_out", reg_out, packed_model());
      end

      // Nonzero read data ahead of the reset check
      hw_load(0, 16'h5A5A);
      access(13'o17770, 1, 0, 0, 16'h0, rdata, lat, iow);
      chk("rd_reg0", {48'b0, rdata}, 64'h5A5A);

      // Three-wait-state instance: request dropped in WAIT aborts
      iopage_addr = 13'o17770; data_in = 16'hBEEF; iopage_byte_op = 1'b0; wr3 = 1'b1;
      @(posedge clk); #1;
      wr3 = 1'b0;
      any_ack = 0; iow3 = '0;
      repeat (5) begin @(posedge clk); #1; if (ack3) any_ack = 1; iow3 |= io_wr3; end
      chk("abort_no_ack", 64'(any_ack), 64'd0);
      chk("abort_no_io_wr", {60'b0, iow3}, 64'd0);
      chk("abort_no_commit", {48'b0, reg_out3[15:0]}, 64'd0);

      wr3 = 1'b1; lat = 0;
      while (!ack3 && lat < 20) begin @(posedge clk); #1; lat++; end
      chk("ws3_lat", 64'(lat), 64'd4);
      chk("ws3_reg0", {48'b0, reg_out3[15:0]}, 64'hBEEF);
      wr3 = 1'b0;
      @(posedge clk); #1;

      // Reset asserted while both instances are mid-access
      iopage_addr = 13'o17772; data_in = 16'h7777; iopage_rd = 1'b1; wr3 = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; iopage_rd = 1'b0; wr3 = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      for (int i = 0; i < 4; i++) model[i] = 16'h0000;
      chk("rst_mid_reg_out", reg_out, packed_model());
      chk("rst_mid_data_out", {48'b0, data_out}, 64'd0);
      chk("rst_mid_reg_out3", reg_out3, 64'd0);
      any_ack = 0;
      repeat (4) begin @(posedge clk); #1; if (ack || ack3 || io_wr != 0 || io_wr3 != 0) any_ack = 1; end
      chk("rst_mid_quiet", 64'(any_ack), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
